// File: rtl/conv3x3_systolic_array.sv
// Weight-stationary 3x3 systolic array: valid-mode 3x3 correlation of a 4x4 image into a 2x2 result.
// Define SYSTOLIC_SAT_EN to saturate outputs at 2^DATA_W-1 instead of wrapping modulo 2^DATA_W.
module conv3x3_systolic_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] i00_i,
  input  logic [DATA_W-1:0] i01_i,
  input  logic [DATA_W-1:0] i02_i,
  input  logic [DATA_W-1:0] i03_i,
  input  logic [DATA_W-1:0] i10_i,
  input  logic [DATA_W-1:0] i11_i,
  input  logic [DATA_W-1:0] i12_i,
  input  logic [DATA_W-1:0] i13_i,
  input  logic [DATA_W-1:0] i20_i,
  input  logic [DATA_W-1:0] i21_i,
  input  logic [DATA_W-1:0] i22_i,
  input  logic [DATA_W-1:0] i23_i,
  input  logic [DATA_W-1:0] i30_i,
  input  logic [DATA_W-1:0] i31_i,
  input  logic [DATA_W-1:0] i32_i,
  input  logic [DATA_W-1:0] i33_i,
  input  logic [DATA_W-1:0] f00_i,
  input  logic [DATA_W-1:0] f01_i,
  input  logic [DATA_W-1:0] f02_i,
  input  logic [DATA_W-1:0] f10_i,
  input  logic [DATA_W-1:0] f11_i,
  input  logic [DATA_W-1:0] f12_i,
  input  logic [DATA_W-1:0] f20_i,
  input  logic [DATA_W-1:0] f21_i,
  input  logic [DATA_W-1:0] f22_i,
  output logic [DATA_W-1:0] o00_o,
  output logic [DATA_W-1:0] o01_o,
  output logic [DATA_W-1:0] o10_o,
  output logic [DATA_W-1:0] o11_o
);

  localparam logic [3:0] CntLast = 4'd13;

  logic [DATA_W-1:0] img [4][4];
  logic [DATA_W-1:0] flt [3][3];

  assign img[0][0] = i00_i;
  assign img[0][1] = i01_i;
  assign img[0][2] = i02_i;
  assign img[0][3] = i03_i;
  assign img[1][0] = i10_i;
  assign img[1][1] = i11_i;
  assign img[1][2] = i12_i;
  assign img[1][3] = i13_i;
  assign img[2][0] = i20_i;
  assign img[2][1] = i21_i;
  assign img[2][2] = i22_i;
  assign img[2][3] = i23_i;
  assign img[3][0] = i30_i;
  assign img[3][1] = i31_i;
  assign img[3][2] = i32_i;
  assign img[3][3] = i33_i;

  assign flt[0][0] = f00_i;
  assign flt[0][1] = f01_i;
  assign flt[0][2] = f02_i;
  assign flt[1][0] = f10_i;
  assign flt[1][1] = f11_i;
  assign flt[1][2] = f12_i;
  assign flt[2][0] = f20_i;
  assign flt[2][1] = f21_i;
  assign flt[2][2] = f22_i;

  logic [3:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]  pe_q [9];
  logic [ACC_W-1:0]  pe_d [9];
  logic [DATA_W-1:0] res_q [4];
  logic [DATA_W-1:0] res_d;

  assign cnt_d = (cnt_q == CntLast) ? cnt_q : cnt_q + 4'd1;

  // PE j (chain order) holds window (cnt - j) during the current cycle; outside 0..3 it is a bubble.
  for (genvar j = 0; j < 9; j++) begin : g_pe
    localparam int R = j / 3;
    localparam int C = j % 3;

    logic [4:0]        win;
    logic [DATA_W-1:0] pix;
    logic [ACC_W-1:0]  sum_in;

    assign win = {1'b0, cnt_q} - 5'(j);

    always_comb begin
      pix = '0;
      if (win < 5'd4) begin
        unique case (win[1:0])
          2'd0:    pix = img[R][C];
          2'd1:    pix = img[R][C+1];
          2'd2:    pix = img[R+1][C];
          default: pix = img[R+1][C+1];
        endcase
      end
    end

    if (j == 0) begin : g_head
      assign sum_in = '0;
    end else begin : g_link
      assign sum_in = pe_q[j-1];
    end

    assign pe_d[j] = sum_in + ACC_W'(pix) * ACC_W'(flt[R][C]);
  end

`ifdef SYSTOLIC_SAT_EN
  assign res_d = (|pe_q[8][ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : pe_q[8][DATA_W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^pe_q[8][ACC_W-1:DATA_W];
  assign res_d     = pe_q[8][DATA_W-1:0];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int j = 0; j < 9; j++) pe_q[j] <= '0;
      for (int k = 0; k < 4; k++) res_q[k] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int j = 0; j < 9; j++) pe_q[j] <= pe_d[j];
      // Window k exits the chain while cnt == k+9.
      case (cnt_q)
        4'd9:    res_q[0] <= res_d;
        4'd10:   res_q[1] <= res_d;
        4'd11:   res_q[2] <= res_d;
        4'd12:   res_q[3] <= res_d;
        default: ;
      endcase
    end
  end

  assign o00_o = res_q[0];
  assign o01_o = res_q[1];
  assign o10_o = res_q[2];
  assign o11_o = res_q[3];

endmodule

// File: tb/tb_conv3x3_systolic_array.sv
// Bench for conv3x3_systolic_array: per-cycle comparison against a direct-sum model plus literal checks.
module tb_conv3x3_systolic_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] img [4][4];
  logic [7:0] flt [3][3];
  logic [7:0] dut_o [4];

  int checks = 0;
  int errors = 0;

  int         edge_q;
  logic [7:0] exp_q [4];

  always #5 clk = ~clk;

  conv3x3_systolic_array dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .i00_i (img[0][0]), .i01_i(img[0][1]), .i02_i(img[0][2]), .i03_i(img[0][3]),
    .i10_i (img[1][0]), .i11_i(img[1][1]), .i12_i(img[1][2]), .i13_i(img[1][3]),
    .i20_i (img[2][0]), .i21_i(img[2][1]), .i22_i(img[2][2]), .i23_i(img[2][3]),
    .i30_i (img[3][0]), .i31_i(img[3][1]), .i32_i(img[3][2]), .i33_i(img[3][3]),
    .f00_i (flt[0][0]), .f01_i(flt[0][1]), .f02_i(flt[0][2]),
    .f10_i (flt[1][0]), .f11_i(flt[1][1]), .f12_i(flt[1][2]),
    .f20_i (flt[2][0]), .f21_i(flt[2][1]), .f22_i(flt[2][2]),
    .o00_o (dut_o[0]),
    .o01_o (dut_o[1]),
    .o10_o (dut_o[2]),
    .o11_o (dut_o[3])
  );

  // Output k = window with origin (k/2, k%2), plain multiply-accumulate.
  function automatic int model(int k);
    int a = k / 2;
    int b = k % 2;
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += int'(img[a+r][b+c]) * int'(flt[r][c]);
`ifdef SYSTOLIC_SAT_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Edge n after release; output k becomes valid at edge k+10 and then freezes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= 0;
      for (int k = 0; k < 4; k++) exp_q[k] <= 8'd0;
    end else begin
      edge_q <= edge_q + 1;
      for (int k = 0; k < 4; k++)
        if (edge_q + 1 == k + 10) exp_q[k] <= 8'(model(k));
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) chk($sformatf("cycle_o%0d", k), int'(dut_o[k]), int'(exp_q[k]));
  end

  task automatic set_nominal();
    int im [16] = '{8, 3, 9, 1, 7, 7, 2, 8, 5, 6, 3, 1, 4, 9, 2, 6};
    int fl [9]  = '{1, 5, 8, 6, 0, 7, 3, 1, 2};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'(im[r*4+c]);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) flt[r][c] = 8'(fl[r*3+c]);
  endtask

  task automatic assert_rst();
    @(negedge clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_all(input string tag, input int e0, input int e1, input int e2,
                            input int e3);
    chk({tag, "_o00"}, int'(dut_o[0]), e0);
    chk({tag, "_o01"}, int'(dut_o[1]), e1);
    chk({tag, "_o10"}, int'(dut_o[2]), e2);
    chk({tag, "_o11"}, int'(dut_o[3]), e3);
  endtask

  initial begin
    set_nominal();
    chk("model_o00", model(0), 178);
    chk("model_o01", model(1), 177);
    chk("model_o10", model(2), 134);
    chk("model_o11", model(3), 165);
    #25;
    expect_all("in_reset", 0, 0, 0, 0);
    #5 rst_n = 1'b1;  // released at t=30, edge 1 at t=35

    // Edge 10 partial check: o00 valid, others still zero.
    repeat (10) @(posedge clk);
    #1 expect_all("edge10", 178, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 expect_all("edge13", 178, 177, 134, 165);

    // Late input change during hold.
    repeat (5) @(posedge clk);
    #2;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'd0;
    repeat (50) @(posedge clk);
    #1 expect_all("hold_late", 178, 177, 134, 165);

    // Asynchronous clear without a clock edge.
    assert_rst();
    #1 expect_all("async_clr", 0, 0, 0, 0);

    // Identity filter.
    set_nominal();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) flt[r][c] = 8'd0;
    flt[1][1] = 8'd1;
    release_rst();
    repeat (16) @(posedge clk);
    #1 expect_all("ident", 7, 2, 6, 3);

    // All full-scale.
    assert_rst();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'd255;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) flt[r][c] = 8'd255;
    release_rst();
    repeat (16) @(posedge clk);
`ifdef SYSTOLIC_SAT_EN
    #1 expect_all("ovf", 255, 255, 255, 255);
`else
    #1 expect_all("ovf", 9, 9, 9, 9);
`endif

    // Reset between edges 11 and 12, then full rerun.
    assert_rst();
    set_nominal();
    release_rst();
    repeat (11) @(posedge clk);
    #1 expect_all("pre_mid", 178, 177, 0, 0);
    #2 rst_n = 1'b0;
    #1 expect_all("mid_clr", 0, 0, 0, 0);
    release_rst();
    repeat (9) @(posedge clk);
    #1 expect_all("rerun_e9", 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 expect_all("rerun", 178, 177, 134, 165);
    repeat (3) @(posedge clk);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_systolic_array.md
Name: conv3x3_systolic_array

Overview:
- Weight-stationary 3x3 systolic array that computes a valid-mode 2D correlation of a 4x4 unsigned 8-bit image with a 3x3 unsigned 8-bit filter.
- Produces a 2x2 result (no filter flip).
- Used as the convolution engine of the systolic datapath.
- Image and filter arrive as static parallel buses. After reset release the block runs one fixed schedule, then holds its results.

Parameters:
- DATA_W, 8, width of each image, filter and output element.
- ACC_W, 20, internal partial-sum width (2*DATA_W+4; holds 9 full-scale products without overflow).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low (0 = in reset)
- i00..i33  input  DATA_W each (16 ports)  image pixel i[row][col], row/col 0..3
- f00..f22  input  DATA_W each (9 ports)  filter tap f[row][col], row/col 0..2
- o00, o01, o10, o11  output  DATA_W each  result o[a][b] = sum over r,c of i[a+r][b+c]*f[r][c], truncated per Behaviour

Behaviour:
- Reset (rst=0, asynchronous): all PE registers, partial sums, the schedule counter and all outputs clear to 0. Outputs read 0 for the whole reset.
- Reset release: the edge numbering below starts at the first rising edge of clk with rst=1 (edge 1).
- Array structure:
  - 9 PEs, PE(r,c) holds stationary weight f[r][c].
  - Partial sums travel one PE per clock along the chain (0,0)->(0,1)->(0,2)->(1,0)->...->(2,2).
  - Each PE adds pixel*weight, then registers the result (ACC_W bits, unsigned).
- Window order: k=0 is o00, k=1 is o01, k=2 is o10, k=3 is o11. Window k with origin (a,b) enters PE(0,0) at edge k+1.
- Pixel selection: while window (a,b) sits at PE(r,c), the PE multiplies i[a+r][b+c]. Pixel muxing is driven by a 4-bit schedule counter.
- Chain exit: window k leaves PE(2,2) at edge k+9.
- Output capture: window k is captured into its output register at edge k+10. So o00 updates at edge 10, o01 at 11, o10 at 12, o11 at 13.
- Hold: after edge 13 the schedule counter saturates, no new windows are injected, and the outputs hold until the next reset. Injection stops after k=3, and bubbles carry sum 0 but are never captured.
- Input timing: inputs are sampled in the cycle they are consumed. Changing inputs mid-schedule affects only windows that have not yet consumed those pixels. Changes after edge 13 have no effect.
- Output width rule: output = low DATA_W bits of the ACC_W sum (modulo 256). This is the default, without the optional feature.
- Reset mid-operation: everything clears at once and outputs go to 0. The schedule restarts from edge 1 after release.
- Internal accumulation never overflows (ACC_W=20 is at least log2(9*255*255)).

Optional Feature:
- Macro: SYSTOLIC_SAT_EN
- Defined: each output is min(sum, 2^DATA_W-1), i.e. it saturates at 255.
- Undefined: output is sum modulo 2^DATA_W.
- Latency, reset behaviour and the schedule are identical in both builds.

Test Plan:
- Nominal run:
  - Image rows {8,3,9,1},{7,7,2,8},{5,6,3,1},{4,9,2,6}; filter {1,5,8},{6,0,7},{3,1,2}.
  - rst=0 for 30 ns, then 1, with a 10 ns clock.
  - Required: o00=178 at edge 10, o01=177 at edge 11, o10=134 at edge 12, o11=165 at edge 13. All four hold for 500 ns.
- Reset behaviour:
  - Required: all outputs read 0 during the initial reset and at every edge before their capture edge.
  - Re-asserting rst=0 after the run zeroes all outputs immediately, without waiting for a clock.
- Identity filter:
  - Filter with f11=1 and all other taps 0, nominal image.
  - Required: o00=7, o01=2, o10=6, o11=3, at edges 10-13.
- Overflow:
  - All pixels and taps = 255.
  - Required: every output = 9 without SYSTOLIC_SAT_EN, and 255 with it.
- Mid-run reset:
  - Drop rst to 0 between edges 11 and 12, then release.
  - Required: o00 and o01 clear to 0 immediately. The full schedule repeats and gives 178/177/134/165 at edges 10-13 after the new release.
- Late input change:
  - Change every image pixel to 0 after edge 13.
  - Required: outputs still hold 178/177/134/165.
